// File: rtl/mcp_tx_sched_pkg.sv
// Shared types and constants for the mcp_tx_sched source-domain scheduler.
// Optional build macro: MCP_TX_SCHED_ACK_EN (destination ack gating of HOLD exit).
package mcp_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    HOLD   = 2'b10
  } state_e;

  localparam int XFER_CNT_W      = 16;
  localparam int DEF_HOLD_CYCLES = 6;

  // Index width that stays at least 1 bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcp_tx_sched_if.sv
// Requester/channel bundle for mcp_tx_sched. slave = scheduler side, master = requesters/monitor.
// With MCP_TX_SCHED_ACK_EN the synchronised destination ack toggle joins the bundle.
interface mcp_tx_sched_if
  import mcp_tx_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   cntl_a;
  logic [WIDTH-1:0]       data_a;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic [XFER_CNT_W-1:0]  xfer_cnt;
`ifdef MCP_TX_SCHED_ACK_EN
  logic                   ack_tgl_a;
`endif

  modport slave (
`ifdef MCP_TX_SCHED_ACK_EN
    input  ack_tgl_a,
`endif
    input  req_valid, req_data,
    output req_ready, cntl_a, data_a, grant_id, busy, xfer_cnt
  );

  modport master (
`ifdef MCP_TX_SCHED_ACK_EN
    output ack_tgl_a,
`endif
    output req_valid, req_data,
    input  req_ready, cntl_a, data_a, grant_id, busy, xfer_cnt
  );

endinterface

// File: rtl/mcp_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1, wrapping.
// The pointer register lives in the parent.
module rr_arbiter
  import mcp_tx_sched_pkg::*;
#(
  parameter int N   = 4,
  localparam int IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  // Scan N positions starting after the last winner; first hit wins.
  always_comb begin
    int   j;
    logic found;
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (en && !found && req[IDW'(j)]) begin
        found   = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mcp_tx_sched.sv
// Source-domain scheduler for the MCP/gray-counter CDC channel: round-robin accept,
// one-cycle launch pulse, then a quiet HOLD window with data_a held stable.
// Optional build macro: MCP_TX_SCHED_ACK_EN -- HOLD also waits for ack_tgl_a == exp_tgl.
module mcp_tx_sched
  import mcp_tx_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic             clk_a,
  input logic             rst_n_a,
  mcp_tx_sched_if.slave   bus
);

  localparam int IDW = idx_w(N_REQ);
  localparam int CW  = idx_w(HOLD_CYCLES);

  state_e                     state_q, state_d;
  logic [IDW-1:0]             ptr_q, gnt_idx, gid_q;
  logic [N_REQ-1:0]           gnt;
  logic [CW-1:0]              cnt_q;
  logic [WIDTH-1:0]           data_q;
  logic [XFER_CNT_W-1:0]      xfer_q;
  logic [N_REQ-1:0][WIDTH-1:0] req_lane;
  logic                       arb_en, accept, hold_done;

  assign req_lane = bus.req_data;
  // Reset gating keeps req_ready quiet while rst_n_a is low even with valids up.
  assign arb_en   = (state_q == IDLE) && rst_n_a;
  assign accept   = |gnt;

`ifdef MCP_TX_SCHED_ACK_EN
  logic exp_tgl_q;
  assign hold_done = (cnt_q == '0) && (bus.ack_tgl_a == exp_tgl_q);
`else
  assign hold_done = (cnt_q == '0);
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: IDLE -> LAUNCH on accept, LAUNCH is one cycle, HOLD until done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = HOLD;
      HOLD:    if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, count launches, run the hold counter.
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      ptr_q     <= IDW'(N_REQ - 1);
      gid_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      xfer_q    <= '0;
`ifdef MCP_TX_SCHED_ACK_EN
      exp_tgl_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        data_q <= req_lane[gnt_idx];
        gid_q  <= gnt_idx;
        ptr_q  <= gnt_idx;
      end
      if (state_q == LAUNCH) begin
        xfer_q    <= xfer_q + XFER_CNT_W'(1);
        cnt_q     <= CW'(HOLD_CYCLES - 1);
`ifdef MCP_TX_SCHED_ACK_EN
        exp_tgl_q <= ~exp_tgl_q;
`endif
      end
      // Counter parks at zero while an ack is still outstanding.
      if (state_q == HOLD && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bus.req_ready = gnt;
  assign bus.cntl_a    = (state_q == LAUNCH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.data_a    = data_q;
  assign bus.grant_id  = gid_q;
  assign bus.xfer_cnt  = xfer_q;

endmodule
